// File: rtl/pipe_ctrl.sv
// pipe_ctrl: MINAv2 hazard/stall controller producing stage enables, bubbles,
// PC write enable and a saturating stall-cycle counter.
package pipe_ctrl_pkg;
  typedef logic [4:0] regaddr_t;
endpackage

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  regaddr_t         ra_addr_if_id,
  input  regaddr_t         rb_addr_if_id,
  input  logic             ra_used_if_id,
  input  logic             rb_used_if_id,
  input  regaddr_t         rd_addr_id_ex,
  input  logic             is_load_id_ex,
  input  logic             is_md_id_ex,
  input  logic             branch_taken_ex,
  input  logic             md_done,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  input  logic             cnt_clr,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             md_start,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, MD_WAIT} st_t;

  st_t              r_st, w_st_nxt;
  logic             r_md_seen, r_md_busy;
  logic [CNT_W-1:0] r_cnt;
  logic             w_mem, w_md_wait, w_lu, w_run;

  assign w_mem     = dmem_req & ~dmem_ack;
  assign w_md_wait = is_md_id_ex & ~(md_done | r_md_seen);
  assign w_lu      = is_load_id_ex & (|rd_addr_id_ex) &
                     ((ra_used_if_id & (ra_addr_if_id == rd_addr_id_ex)) |
                      (rb_used_if_id & (rb_addr_if_id == rd_addr_id_ex)));
  assign w_run     = rst_n & ~w_mem & ~w_md_wait;
  assign w_st_nxt  = w_mem ? MEM_WAIT : w_md_wait ? MD_WAIT : RUN;

  // A taken branch wins over a load-use stall; everything is held low during reset
  assign pc_we        = w_run & (branch_taken_ex | ~w_lu);
  assign if_id_we     = pc_we;
  assign id_ex_we     = w_run;
  assign ex_mem_we    = rst_n & ~w_mem;
  assign mem_wb_we    = rst_n;
  assign if_id_flush  = w_run & branch_taken_ex;
  assign id_ex_flush  = w_run & (branch_taken_ex | w_lu);
  assign ex_mem_flush = rst_n & ~w_mem & w_md_wait;
  assign mem_wb_flush = rst_n & w_mem;
  // r_md_busy remembers an issued start across a memory stall so it is never reissued
  assign md_start     = rst_n & ~w_mem & w_md_wait & (r_st != MD_WAIT) & ~r_md_busy;
  assign stall_cnt    = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st      <= RUN;
      r_md_seen <= 1'b0;
      r_md_busy <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_st      <= w_st_nxt;
      r_md_seen <= is_md_id_ex & w_mem & (r_md_seen | md_done);
      r_md_busy <= is_md_id_ex & (w_mem | w_md_wait) & (r_md_busy | md_start);
      r_cnt     <= cnt_clr ? '0 : (~pc_we & ~&r_cnt) ? r_cnt + CNT_W'(1) : r_cnt;
    end
  end
endmodule
